// File: rtl/ras_ckpt_pkg.sv
// rtl/ras_ckpt_pkg.sv - shared constants, types and helpers for the checkpointed return-address stack
package ras_ckpt_pkg;

  localparam int RAS_ENTRIES_NUM = 16;
  localparam int RAS_DATA_W      = 33;
  localparam int RAS_PTR_W       = $clog2(RAS_ENTRIES_NUM);
  localparam int RAS_CNT_W       = $clog2(RAS_ENTRIES_NUM + 1);

  typedef struct packed {
    logic [RAS_PTR_W-1:0]  tos;
    logic [RAS_CNT_W-1:0]  count;
    logic [RAS_DATA_W-1:0] top_data;
  } ras_ckpt_t;

  typedef enum logic [1:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_REPL
  } ras_op_e;

  function automatic int ras_ckpt_w(int entries, int data_w);
    return $clog2(entries) + $clog2(entries + 1) + data_w;
  endfunction

endpackage

// File: rtl/ras_ckpt_if.sv
// rtl/ras_ckpt_if.sv - fetch-side request/response bundle of the return-address stack
interface ras_ckpt_if
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES_NUM = RAS_ENTRIES_NUM,
  parameter int DATA_W      = RAS_DATA_W
);
  localparam int CNT_W  = $clog2(ENTRIES_NUM + 1);
  localparam int CKPT_W = ras_ckpt_w(ENTRIES_NUM, DATA_W);

  logic              flush;
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic              recover_req;
  logic [CKPT_W-1:0] recover_ckpt;
  logic              top_valid;
  logic [DATA_W-1:0] top_data;
  logic [CKPT_W-1:0] ckpt_out;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, push_req, pop_req, push_data, recover_req, recover_ckpt,
    input  top_valid, top_data, ckpt_out, count, overflow, underflow
  );

  modport slave (
    input  flush, push_req, pop_req, push_data, recover_req, recover_ckpt,
    output top_valid, top_data, ckpt_out, count, overflow, underflow
  );

endinterface

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - circular return-address stack with per-cycle checkpoint and mispredict recovery
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES_NUM = RAS_ENTRIES_NUM,
  parameter int DATA_W      = RAS_DATA_W
) (
  input  logic       clk,
  input  logic       resetn,
  ras_ckpt_if.slave  bus
);
  localparam int PTR_W  = $clog2(ENTRIES_NUM);
  localparam int CNT_W  = $clog2(ENTRIES_NUM + 1);
  localparam int CKPT_W = PTR_W + CNT_W + DATA_W;

  logic [DATA_W-1:0] r_mem [ENTRIES_NUM];
  logic [PTR_W-1:0]  r_tos;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic [PTR_W-1:0]  w_tos_inc;
  logic [PTR_W-1:0]  w_tos_dec;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_ck_tos;
  logic [CNT_W-1:0]  w_ck_count;
  logic [DATA_W-1:0] w_ck_data;
  ras_op_e           w_op;

  assign w_tos_inc  = r_tos + PTR_W'(1);
  assign w_tos_dec  = r_tos - PTR_W'(1);
  assign w_full     = (r_count == CNT_W'(ENTRIES_NUM));
  assign w_empty    = (r_count == '0);

  assign w_ck_tos   = bus.recover_ckpt[CKPT_W-1 -: PTR_W];
  assign w_ck_count = bus.recover_ckpt[DATA_W +: CNT_W];
  assign w_ck_data  = bus.recover_ckpt[DATA_W-1:0];

  always_comb begin
    w_op = RAS_OP_NONE;
    if (bus.push_req && bus.pop_req) w_op = RAS_OP_REPL;
    else if (bus.push_req)           w_op = RAS_OP_PUSH;
    else if (bus.pop_req)            w_op = RAS_OP_POP;
  end

  always_ff @(posedge clk) begin
    if (!resetn || bus.flush) begin
      r_tos       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < ENTRIES_NUM; i++) r_mem[i] <= '0;
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      if (bus.recover_req) begin
        // Only the top entry is restored; older entries were never overwritten by pops.
        r_tos            <= w_ck_tos;
        r_count          <= w_ck_count;
        r_mem[w_ck_tos]  <= w_ck_data;
      end else begin
        case (w_op)
          RAS_OP_REPL: begin
            r_mem[r_tos] <= bus.push_data;
            if (w_empty) r_count <= CNT_W'(1);
          end
          RAS_OP_PUSH: begin
            r_tos            <= w_tos_inc;
            r_mem[w_tos_inc] <= bus.push_data;
            if (w_full) r_overflow <= 1'b1;
            else        r_count    <= r_count + CNT_W'(1);
          end
          RAS_OP_POP: begin
            if (w_empty) begin
              r_underflow <= 1'b1;
            end else begin
              r_tos   <= w_tos_dec;
              r_count <= r_count - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.top_valid = !w_empty;
  assign bus.top_data  = w_empty ? '0 : r_mem[r_tos];
  assign bus.ckpt_out  = {r_tos, r_count, r_mem[r_tos]};
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed and randomized bench for ras_ckpt against a queue-free array model
module tb_ras_ckpt;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int PW  = 2;
  localparam int CW  = 3;
  localparam int CKW = PW + CW + DW;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ras_ckpt_if #(.ENTRIES_NUM(N), .DATA_W(DW)) bus ();

  ras_ckpt #(.ENTRIES_NUM(N), .DATA_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  int          m_tos;
  int          m_cnt;
  logic [DW-1:0] m_mem [N];
  bit          m_ov;
  bit          m_un;

  function automatic logic [CKW-1:0] model_ckpt();
    return {PW'(m_tos), CW'(m_cnt), m_mem[m_tos]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_apply(input bit rn, input bit fl, input bit ps, input bit pp,
                             input logic [DW-1:0] d, input bit rc, input logic [CKW-1:0] ck);
    int t;
    m_ov = 0;
    m_un = 0;
    if (!rn || fl) begin
      m_tos = 0;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
    end else if (rc) begin
      t = int'(ck[CKW-1 -: PW]);
      m_tos = t;
      m_cnt = int'(ck[DW +: CW]);
      m_mem[t] = ck[DW-1:0];
    end else if (ps && pp) begin
      m_mem[m_tos] = d;
      if (m_cnt == 0) m_cnt = 1;
    end else if (ps) begin
      m_tos = (m_tos + 1) % N;
      m_mem[m_tos] = d;
      if (m_cnt == N) m_ov = 1;
      else m_cnt = m_cnt + 1;
    end else if (pp) begin
      if (m_cnt == 0) m_un = 1;
      else begin
        m_tos = (m_tos + N - 1) % N;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     64'(bus.count),     64'(m_cnt));
    chk({tag, ".top_valid"}, 64'(bus.top_valid), 64'(m_cnt != 0));
    chk({tag, ".top_data"},  64'(bus.top_data),  (m_cnt == 0) ? 64'd0 : 64'(m_mem[m_tos]));
    chk({tag, ".ckpt_out"},  64'(bus.ckpt_out),  64'(model_ckpt()));
    chk({tag, ".overflow"},  64'(bus.overflow),  64'(m_ov));
    chk({tag, ".underflow"}, 64'(bus.underflow), 64'(m_un));
  endtask

  task automatic step(input string tag, input bit rn, input bit fl, input bit ps, input bit pp,
                      input logic [DW-1:0] d, input bit rc, input logic [CKW-1:0] ck);
    resetn           = rn;
    bus.flush        = fl;
    bus.push_req     = ps;
    bus.pop_req      = pp;
    bus.push_data    = d;
    bus.recover_req  = rc;
    bus.recover_ckpt = ck;
    @(posedge clk);
    model_apply(rn, fl, ps, pp, d, rc, ck);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);     step(tag, 1, 0, 0, 0, '0, 0, '0); endtask
  task automatic push(input string tag, input logic [DW-1:0] d); step(tag, 1, 0, 1, 0, d, 0, '0); endtask
  task automatic pop(input string tag);      step(tag, 1, 0, 0, 1, '0, 0, '0); endtask
  task automatic rst(input string tag);      step(tag, 0, 0, 0, 0, '0, 0, '0); endtask

  logic [CKW-1:0] saved;

  initial begin
    m_tos = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_mem[i] = 'x;
    saved = '0;

    rst("reset");
    chk("reset.count0", 64'(bus.count), 64'd0);
    chk("reset.tos0",   64'(bus.ckpt_out[CKW-1 -: PW]), 64'd0);

    push("t2.pushA", 16'hA);
    push("t2.pushB", 16'hB);
    push("t2.pushC", 16'hC);
    chk("t2.topC", 64'(bus.top_data), 64'hC);
    pop("t2.pop1");
    chk("t2.topB", 64'(bus.top_data), 64'hB);
    pop("t2.pop2");
    chk("t2.topA", 64'(bus.top_data), 64'hA);
    chk("t2.cnt1", 64'(bus.count), 64'd1);

    rst("t3.rst");
    for (int v = 1; v <= 5; v++) push("t3.push", DW'(v));
    chk("t3.ovf", 64'(bus.overflow), 64'd1);
    chk("t3.cnt4", 64'(bus.count), 64'd4);
    idle("t3.ovf_clear");
    for (int v = 5; v >= 2; v--) begin
      chk("t3.popval", 64'(bus.top_data), 64'(v));
      pop("t3.pop");
    end
    chk("t3.empty", 64'(bus.count), 64'd0);
    pop("t3.under");
    chk("t3.unf", 64'(bus.underflow), 64'd1);

    rst("t4.rst");
    push("t4.pushA", 16'hA);
    push("t4.pushB", 16'hB);
    step("t4.repl", 1, 0, 1, 1, 16'h5A5A, 0, '0);
    chk("t4.topX", 64'(bus.top_data), 64'h5A5A);
    chk("t4.cnt2", 64'(bus.count), 64'd2);
    pop("t4.pop");
    chk("t4.topA", 64'(bus.top_data), 64'hA);
    pop("t4.pop_last");
    step("t4.repl_empty", 1, 0, 1, 1, 16'h77, 0, '0);

    rst("t5.rst");
    push("t5.pushA", 16'hA);
    push("t5.pushB", 16'hB);
    saved = model_ckpt();
    pop("t5.pop1");
    push("t5.pushZ", 16'h2222);
    step("t5.recover", 1, 0, 0, 0, '0, 1, saved);
    chk("t5.topB", 64'(bus.top_data), 64'hB);
    pop("t5.pop");
    chk("t5.topA", 64'(bus.top_data), 64'hA);

    rst("t5b.rst");
    push("t5b.pushA", 16'hA);
    push("t5b.pushB", 16'hB);
    saved = model_ckpt();
    pop("t5b.pop1");
    pop("t5b.pop2");
    push("t5b.pushZ", 16'h2222);
    step("t5b.recover", 1, 0, 0, 0, '0, 1, saved);
    chk("t5b.cnt2", 64'(bus.count), 64'd2);
    pop("t5b.pop");

    push("t6.push", 16'h1);
    step("t6.flush_wins", 1, 1, 1, 0, 16'h9, 1, saved);
    chk("t6.flush_cnt0", 64'(bus.count), 64'd0);
    push("t6.push2", 16'h3);
    saved = model_ckpt();
    push("t6.push3", 16'h4);
    step("t6.rec_push", 1, 0, 1, 0, 16'hEE, 1, saved);
    chk("t6.push_dropped", 64'(bus.top_data), 64'h3);
    push("t6.push4", 16'h6);
    rst("t6.midreset");
    chk("t6.rst_cnt0", 64'(bus.count), 64'd0);

    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       rst("rnd.rst");
      else if (r < 4)  step("rnd.flush", 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom), 0, '0);
      else if (r < 12) step("rnd.recover", 1, 0, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom), 1, saved);
      else begin
        step("rnd.op", 1, 0, (r % 3) != 0, (r % 2) == 0, DW'($urandom), 0, '0);
        if ((r % 7) == 0) saved = model_ckpt();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
